// File: rtl/alu_pkg.sv
// Shared ALU control encodings and datapath width defaults for the core.
// Imported by the ID/EX stage and its operand forwarding mux.
package alu_pkg;

  localparam int RW_DEF = 5;
  localparam int XW_DEF = 32;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_AND = 4'b0001,
    ALU_XOR = 4'b0010,
    ALU_SLL = 4'b0011,
    ALU_SUB = 4'b0100,
    ALU_OR  = 4'b0101,
    ALU_LUI = 4'b0110,
    ALU_SRL = 4'b0111,
    ALU_SRA = 4'b1111
  } alu_op_e;

endpackage

// File: rtl/fwd_mux.sv
// Resolves one source operand: the youngest in-flight writer wins over older
// ones, and the register file is the fallback. Register $0 is hardwired to zero.
module fwd_mux
  import alu_pkg::*;
#(
  parameter int RW = RW_DEF,
  parameter int XW = XW_DEF
) (
  input  logic [RW-1:0] src,
  input  logic [XW-1:0] reg_val,
  input  logic          ex_fwd_en,
  input  logic [RW-1:0] ex_rd,
  input  logic [XW-1:0] ex_alu_r,
  input  logic          mem_wreg,
  input  logic [RW-1:0] mem_rd,
  input  logic [XW-1:0] mem_data,
  input  logic          wb_wreg,
  input  logic [RW-1:0] wb_rd,
  input  logic [XW-1:0] wb_data,
  output logic [XW-1:0] fwd_val
);

  always_comb begin
    fwd_val = reg_val;
    if (src == '0) begin
      fwd_val = '0;
    end else if (ex_fwd_en && (ex_rd == src)) begin
      fwd_val = ex_alu_r;
    end else if (mem_wreg && (mem_rd == src)) begin
      fwd_val = mem_data;
    end else if (wb_wreg && (wb_rd == src)) begin
      fwd_val = wb_data;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: forwards source operands, builds the ALU a/b/aluc
// triple and inserts a one-cycle bubble on a load-use hazard.
module id_ex_stage
  import alu_pkg::*;
#(
  parameter int RW = RW_DEF,
  parameter int XW = XW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic          id_use_rs,
  input  logic          id_use_rt,
  input  logic [XW-1:0] id_rs_val,
  input  logic [XW-1:0] id_rt_val,
  input  logic [15:0]   id_imm16,
  input  logic [4:0]    id_shamt,
  input  logic [3:0]    id_aluc,
  input  logic          id_alu_src_imm,
  input  logic          id_imm_sext,
  input  logic          id_shift_imm,
  input  logic          id_wreg,
  input  logic          id_m2reg,
  input  logic          id_wmem,
  input  logic          flush,
  input  logic [XW-1:0] ex_alu_r,
  input  logic          mem_wreg,
  input  logic [RW-1:0] mem_rd,
  input  logic [XW-1:0] mem_data,
  input  logic          wb_wreg,
  input  logic [RW-1:0] wb_rd,
  input  logic [XW-1:0] wb_data,
  output logic          stall,
  output logic          ex_valid,
  output logic [XW-1:0] ex_a,
  output logic [XW-1:0] ex_b,
  output logic [3:0]    ex_aluc,
  output logic [RW-1:0] ex_rd,
  output logic          ex_wreg,
  output logic          ex_m2reg,
  output logic          ex_wmem,
  output logic [XW-1:0] ex_store_data
);

  logic          ex_fwd_en;
  logic [XW-1:0] fwd_rs;
  logic [XW-1:0] fwd_rt;
  logic [XW-1:0] imm_ext;
  logic [XW-1:0] op_a;
  logic [XW-1:0] op_b;
  logic          hz;
  logic          bubble;

  // A load in EX has no result yet, so only ALU-producing instructions forward from EX.
  assign ex_fwd_en = ex_valid & ex_wreg & ~ex_m2reg;

  fwd_mux #(.RW(RW), .XW(XW)) u_fwd_rs (
    .src       (id_rs),
    .reg_val   (id_rs_val),
    .ex_fwd_en (ex_fwd_en),
    .ex_rd     (ex_rd),
    .ex_alu_r  (ex_alu_r),
    .mem_wreg  (mem_wreg),
    .mem_rd    (mem_rd),
    .mem_data  (mem_data),
    .wb_wreg   (wb_wreg),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .fwd_val   (fwd_rs)
  );

  fwd_mux #(.RW(RW), .XW(XW)) u_fwd_rt (
    .src       (id_rt),
    .reg_val   (id_rt_val),
    .ex_fwd_en (ex_fwd_en),
    .ex_rd     (ex_rd),
    .ex_alu_r  (ex_alu_r),
    .mem_wreg  (mem_wreg),
    .mem_rd    (mem_rd),
    .mem_data  (mem_data),
    .wb_wreg   (wb_wreg),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .fwd_val   (fwd_rt)
  );

  assign imm_ext = id_imm_sext ? {{(XW-16){id_imm16[15]}}, id_imm16}
                               : {{(XW-16){1'b0}}, id_imm16};
  assign op_a    = id_shift_imm ? {{(XW-5){1'b0}}, id_shamt} : fwd_rs;
  assign op_b    = id_alu_src_imm ? imm_ext : fwd_rt;

  assign hz = id_valid & ex_valid & ex_m2reg & (ex_rd != '0) &
              ((id_use_rs & (ex_rd == id_rs)) | (id_use_rt & (ex_rd == id_rt)));

  // A redirect squashes the waiting instruction, so there is nothing to hold.
  assign stall  = hz & ~flush;
  assign bubble = ~id_valid | flush | hz;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid      <= 1'b0;
      ex_a          <= '0;
      ex_b          <= '0;
      ex_aluc       <= '0;
      ex_rd         <= '0;
      ex_wreg       <= 1'b0;
      ex_m2reg      <= 1'b0;
      ex_wmem       <= 1'b0;
      ex_store_data <= '0;
    end else if (bubble) begin
      ex_valid      <= 1'b0;
      ex_a          <= '0;
      ex_b          <= '0;
      ex_aluc       <= '0;
      ex_rd         <= '0;
      ex_wreg       <= 1'b0;
      ex_m2reg      <= 1'b0;
      ex_wmem       <= 1'b0;
      ex_store_data <= '0;
    end else begin
      ex_valid      <= 1'b1;
      ex_a          <= op_a;
      ex_b          <= op_b;
      ex_aluc       <= id_aluc;
      ex_rd         <= id_rd;
      ex_wreg       <= id_wreg;
      ex_m2reg      <= id_m2reg;
      ex_wmem       <= id_wmem;
      ex_store_data <= fwd_rt;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed vector table, reset and
// load-use sequences, then random stimulus against a behavioural model.
module tb_id_ex_stage;
  import alu_pkg::*;

  typedef struct packed {
    logic        id_valid;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        id_use_rs, id_use_rt;
    logic [31:0] id_rs_val, id_rt_val;
    logic [15:0] id_imm16;
    logic [4:0]  id_shamt;
    logic [3:0]  id_aluc;
    logic        id_alu_src_imm, id_imm_sext, id_shift_imm;
    logic        id_wreg, id_m2reg, id_wmem;
    logic        flush;
    logic [31:0] ex_alu_r;
    logic        mem_wreg;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        wb_wreg;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
  } in_t;

  typedef struct packed {
    logic        stall;
    logic        valid;
    logic [31:0] a, b;
    logic [3:0]  aluc;
    logic [4:0]  rd;
    logic        wreg, m2reg, wmem;
    logic [31:0] sd;
  } exp_t;

  typedef struct packed {
    in_t  i;
    exp_t e;
  } vec_t;

  logic        clk, rst;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_use_rs, id_use_rt;
  logic [31:0] id_rs_val, id_rt_val;
  logic [15:0] id_imm16;
  logic [4:0]  id_shamt;
  logic [3:0]  id_aluc;
  logic        id_alu_src_imm, id_imm_sext, id_shift_imm;
  logic        id_wreg, id_m2reg, id_wmem, flush;
  logic [31:0] ex_alu_r;
  logic        mem_wreg;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        wb_wreg;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        stall, ex_valid;
  logic [31:0] ex_a, ex_b, ex_store_data;
  logic [3:0]  ex_aluc;
  logic [4:0]  ex_rd;
  logic        ex_wreg, ex_m2reg, ex_wmem;

  int n_checks = 0;
  int n_fail   = 0;

  id_ex_stage #(.RW(5), .XW(32)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .id_imm16(id_imm16),
    .id_shamt(id_shamt), .id_aluc(id_aluc), .id_alu_src_imm(id_alu_src_imm),
    .id_imm_sext(id_imm_sext), .id_shift_imm(id_shift_imm), .id_wreg(id_wreg),
    .id_m2reg(id_m2reg), .id_wmem(id_wmem), .flush(flush), .ex_alu_r(ex_alu_r),
    .mem_wreg(mem_wreg), .mem_rd(mem_rd), .mem_data(mem_data),
    .wb_wreg(wb_wreg), .wb_rd(wb_rd), .wb_data(wb_data), .stall(stall),
    .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b), .ex_aluc(ex_aluc),
    .ex_rd(ex_rd), .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_wmem(ex_wmem),
    .ex_store_data(ex_store_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input in_t s);
    id_valid = s.id_valid; id_rs = s.id_rs; id_rt = s.id_rt; id_rd = s.id_rd;
    id_use_rs = s.id_use_rs; id_use_rt = s.id_use_rt;
    id_rs_val = s.id_rs_val; id_rt_val = s.id_rt_val;
    id_imm16 = s.id_imm16; id_shamt = s.id_shamt; id_aluc = s.id_aluc;
    id_alu_src_imm = s.id_alu_src_imm; id_imm_sext = s.id_imm_sext;
    id_shift_imm = s.id_shift_imm;
    id_wreg = s.id_wreg; id_m2reg = s.id_m2reg; id_wmem = s.id_wmem;
    flush = s.flush; ex_alu_r = s.ex_alu_r;
    mem_wreg = s.mem_wreg; mem_rd = s.mem_rd; mem_data = s.mem_data;
    wb_wreg = s.wb_wreg; wb_rd = s.wb_rd; wb_data = s.wb_data;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic checkEx(input string tag, input exp_t e);
    checkOutput({tag, ".valid"}, {31'b0, ex_valid}, {31'b0, e.valid});
    checkOutput({tag, ".a"}, ex_a, e.a);
    checkOutput({tag, ".b"}, ex_b, e.b);
    checkOutput({tag, ".aluc"}, {28'b0, ex_aluc}, {28'b0, e.aluc});
    checkOutput({tag, ".rd"}, {27'b0, ex_rd}, {27'b0, e.rd});
    checkOutput({tag, ".wreg"}, {31'b0, ex_wreg}, {31'b0, e.wreg});
    checkOutput({tag, ".m2reg"}, {31'b0, ex_m2reg}, {31'b0, e.m2reg});
    checkOutput({tag, ".wmem"}, {31'b0, ex_wmem}, {31'b0, e.wmem});
    checkOutput({tag, ".store"}, ex_store_data, e.sd);
  endtask

  // Reference model: the newest producer that writes the register supplies it.
  function automatic logic [31:0] model_operand(input logic [4:0] src, input logic [31:0] rf,
                                                input exp_t ex, input in_t s);
    logic        en[3];
    logic [4:0]  rd[3];
    logic [31:0] val[3];
    if (src == 0) return 32'd0;
    en[0] = ex.valid && ex.wreg && !ex.m2reg; rd[0] = ex.rd;   val[0] = s.ex_alu_r;
    en[1] = s.mem_wreg;                       rd[1] = s.mem_rd; val[1] = s.mem_data;
    en[2] = s.wb_wreg;                        rd[2] = s.wb_rd;  val[2] = s.wb_data;
    for (int k = 0; k < 3; k++) if (en[k] && rd[k] == src) return val[k];
    return rf;
  endfunction

  vec_t tbl[$];
  vec_t v;
  in_t  s;
  exp_t mex, nxt;
  logic hz_m, exp_stall;
  logic [31:0] rs_m, rt_m;

  initial begin
    s = '0;
    applyStimulus(s);
    rst = 1'b1;
    #3;
    checkOutput("reset.stall", {31'b0, stall}, 32'd0);
    checkEx("reset", '0);
    @(negedge clk);
    rst = 1'b0;

    // 0: ADDI with sign-extended 0xFFFF, rt=$0 gives store data 0
    v = '0; v.i.id_valid = 1; v.i.id_rs = 1; v.i.id_use_rs = 1; v.i.id_rs_val = 5;
    v.i.id_rt_val = 32'h99; v.i.id_imm16 = 16'hFFFF; v.i.id_imm_sext = 1;
    v.i.id_alu_src_imm = 1; v.i.id_aluc = ALU_ADD; v.i.id_rd = 2; v.i.id_wreg = 1;
    v.e.valid = 1; v.e.a = 5; v.e.b = 32'hFFFFFFFF; v.e.rd = 2; v.e.wreg = 1;
    tbl.push_back(v);
    // 1: producer of $3
    v = '0; v.i.id_valid = 1; v.i.id_rd = 3; v.i.id_wreg = 1; v.i.id_aluc = ALU_OR;
    v.e.valid = 1; v.e.rd = 3; v.e.wreg = 1; v.e.aluc = ALU_OR;
    tbl.push_back(v);
    // 2: rs=$3 hits EX, MEM and WB -> EX wins
    v = '0; v.i.id_valid = 1; v.i.id_rs = 3; v.i.id_use_rs = 1; v.i.id_rs_val = 32'hDEAD;
    v.i.ex_alu_r = 32'hA; v.i.mem_wreg = 1; v.i.mem_rd = 3; v.i.mem_data = 32'hB;
    v.i.wb_wreg = 1; v.i.wb_rd = 3; v.i.wb_data = 32'hC; v.i.id_rd = 6; v.i.id_wreg = 1;
    v.e.valid = 1; v.e.a = 32'hA; v.e.rd = 6; v.e.wreg = 1;
    tbl.push_back(v);
    // 3: EX no longer writes $3 -> MEM for rs; rt=$7 from WB
    v = '0; v.i.id_valid = 1; v.i.id_rs = 3; v.i.id_use_rs = 1; v.i.id_rt = 7;
    v.i.id_use_rt = 1; v.i.ex_alu_r = 32'hA; v.i.mem_wreg = 1; v.i.mem_rd = 3;
    v.i.mem_data = 32'hB; v.i.wb_wreg = 1; v.i.wb_rd = 7; v.i.wb_data = 32'hC;
    v.i.id_aluc = ALU_SUB;
    v.e.valid = 1; v.e.a = 32'hB; v.e.b = 32'hC; v.e.sd = 32'hC; v.e.aluc = ALU_SUB;
    tbl.push_back(v);
    // 4: lw $4, 8($1)
    v = '0; v.i.id_valid = 1; v.i.id_rs = 1; v.i.id_use_rs = 1; v.i.id_rs_val = 32'h100;
    v.i.id_imm16 = 16'd8; v.i.id_imm_sext = 1; v.i.id_alu_src_imm = 1;
    v.i.id_rd = 4; v.i.id_wreg = 1; v.i.id_m2reg = 1;
    v.e.valid = 1; v.e.a = 32'h100; v.e.b = 8; v.e.rd = 4; v.e.wreg = 1; v.e.m2reg = 1;
    tbl.push_back(v);
    // 5: add $5,$4,$4 -> load-use: stall and bubble
    v = '0; v.i.id_valid = 1; v.i.id_rs = 4; v.i.id_rt = 4; v.i.id_use_rs = 1;
    v.i.id_use_rt = 1; v.i.id_rs_val = 32'h55; v.i.id_rt_val = 32'h55;
    v.i.ex_alu_r = 32'h77; v.i.id_rd = 5; v.i.id_wreg = 1;
    v.e.stall = 1;
    tbl.push_back(v);
    // 6: same add, load now in MEM -> forwarded from mem_data
    v.i.mem_wreg = 1; v.i.mem_rd = 4; v.i.mem_data = 32'h4444;
    v.e = '0; v.e.valid = 1; v.e.a = 32'h4444; v.e.b = 32'h4444; v.e.sd = 32'h4444;
    v.e.rd = 5; v.e.wreg = 1;
    tbl.push_back(v);
    // 7: WB writes $0, ID reads $0 -> operands stay 0
    v = '0; v.i.id_valid = 1; v.i.id_use_rs = 1; v.i.id_use_rt = 1;
    v.i.id_rs_val = 32'h77; v.i.id_rt_val = 32'h88; v.i.ex_alu_r = 32'h9;
    v.i.wb_wreg = 1; v.i.wb_rd = 0; v.i.wb_data = 32'h1234;
    v.e.valid = 1;
    tbl.push_back(v);
    // 8: sll shamt=7
    v = '0; v.i.id_valid = 1; v.i.id_rt = 2; v.i.id_use_rt = 1; v.i.id_rt_val = 3;
    v.i.id_shamt = 7; v.i.id_shift_imm = 1; v.i.id_aluc = ALU_SLL; v.i.id_rd = 9;
    v.i.id_wreg = 1;
    v.e.valid = 1; v.e.a = 7; v.e.b = 3; v.e.sd = 3; v.e.aluc = ALU_SLL; v.e.rd = 9;
    v.e.wreg = 1;
    tbl.push_back(v);
    // 9: lw $10 with zero-extended 0x8004
    v = '0; v.i.id_valid = 1; v.i.id_rs_val = 32'h5; v.i.id_use_rs = 1;
    v.i.id_imm16 = 16'h8004; v.i.id_alu_src_imm = 1; v.i.id_rd = 10;
    v.i.id_wreg = 1; v.i.id_m2reg = 1;
    v.e.valid = 1; v.e.b = 32'h8004; v.e.rd = 10; v.e.wreg = 1; v.e.m2reg = 1;
    tbl.push_back(v);
    // 10: flush with load-use hazard -> bubble, no stall
    v = '0; v.i.id_valid = 1; v.i.id_rs = 10; v.i.id_use_rs = 1; v.i.id_rd = 11;
    v.i.id_wreg = 1; v.i.flush = 1;
    tbl.push_back(v);
    // 11: sw with rt forwarded from WB
    v = '0; v.i.id_valid = 1; v.i.id_rs = 1; v.i.id_use_rs = 1; v.i.id_rs_val = 32'h200;
    v.i.id_rt = 2; v.i.id_use_rt = 1; v.i.id_rt_val = 32'hABCD; v.i.id_imm16 = 16'd4;
    v.i.id_alu_src_imm = 1; v.i.id_imm_sext = 1; v.i.id_wmem = 1;
    v.i.wb_wreg = 1; v.i.wb_rd = 2; v.i.wb_data = 32'h5555;
    v.e.valid = 1; v.e.a = 32'h200; v.e.b = 4; v.e.sd = 32'h5555; v.e.wmem = 1;
    tbl.push_back(v);
    // 12: invalid ID slot -> bubble
    v = '0; v.i.id_rs = 1; v.i.id_rd = 3; v.i.id_wreg = 1;
    tbl.push_back(v);

    foreach (tbl[i]) begin
      @(negedge clk);
      applyStimulus(tbl[i].i);
      #1;
      checkOutput($sformatf("tbl%0d.stall", i), {31'b0, stall}, {31'b0, tbl[i].e.stall});
      @(posedge clk);
      #1;
      checkEx($sformatf("tbl%0d", i), tbl[i].e);
    end

    // Asynchronous reset in mid-cycle while a load sits in EX with a hazard pending
    @(negedge clk);
    s = tbl[4].i;
    applyStimulus(s);
    @(posedge clk);
    #1;
    checkOutput("rstseq.load_valid", {31'b0, ex_m2reg}, 32'd1);
    @(negedge clk);
    s = tbl[5].i;
    applyStimulus(s);
    #1;
    checkOutput("rstseq.stall_before", {31'b0, stall}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rstseq.stall_during", {31'b0, stall}, 32'd0);
    checkEx("rstseq", '0);
    @(negedge clk);
    s = '0;
    applyStimulus(s);
    rst = 1'b0;

    mex = '0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      s.id_valid = ($urandom_range(0, 9) != 0);
      s.id_rs = 5'($urandom_range(0, 3)); s.id_rt = 5'($urandom_range(0, 3));
      s.id_rd = 5'($urandom_range(0, 3));
      s.id_use_rs = 1'($urandom_range(0, 1)); s.id_use_rt = 1'($urandom_range(0, 1));
      s.id_rs_val = $urandom; s.id_rt_val = $urandom;
      s.id_imm16 = 16'($urandom); s.id_shamt = 5'($urandom);
      s.id_aluc = 4'($urandom);
      s.id_alu_src_imm = 1'($urandom_range(0, 1)); s.id_imm_sext = 1'($urandom_range(0, 1));
      s.id_shift_imm = ($urandom_range(0, 3) == 0);
      s.id_wreg = 1'($urandom_range(0, 1)); s.id_m2reg = ($urandom_range(0, 2) == 0);
      s.id_wmem = ($urandom_range(0, 3) == 0);
      s.flush = ($urandom_range(0, 9) == 0);
      s.ex_alu_r = $urandom;
      s.mem_wreg = 1'($urandom_range(0, 1)); s.mem_rd = 5'($urandom_range(0, 3));
      s.mem_data = $urandom;
      s.wb_wreg = 1'($urandom_range(0, 1)); s.wb_rd = 5'($urandom_range(0, 3));
      s.wb_data = $urandom;
      applyStimulus(s);

      rs_m = model_operand(s.id_rs, s.id_rs_val, mex, s);
      rt_m = model_operand(s.id_rt, s.id_rt_val, mex, s);
      hz_m = s.id_valid && mex.valid && mex.m2reg && mex.rd != 0 &&
             ((s.id_use_rs && mex.rd == s.id_rs) || (s.id_use_rt && mex.rd == s.id_rt));
      exp_stall = hz_m && !s.flush;
      nxt = '0;
      if (s.id_valid && !s.flush && !hz_m) begin
        nxt.valid = 1'b1;
        nxt.a     = s.id_shift_imm ? 32'(s.id_shamt) : rs_m;
        if (!s.id_alu_src_imm) nxt.b = rt_m;
        else if (s.id_imm_sext) nxt.b = 32'($signed(s.id_imm16));
        else nxt.b = 32'(s.id_imm16);
        nxt.aluc  = s.id_aluc;
        nxt.rd    = s.id_rd;
        nxt.wreg  = s.id_wreg;
        nxt.m2reg = s.id_m2reg;
        nxt.wmem  = s.id_wmem;
        nxt.sd    = rt_m;
      end

      #1;
      checkOutput($sformatf("rnd%0d.stall", n), {31'b0, stall}, {31'b0, exp_stall});
      @(posedge clk);
      mex = nxt;
      #1;
      checkEx($sformatf("rnd%0d", n), mex);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
